ex_stage: RTL and testbench
===========================

# ex_stage

Execute stage of the 5-stage pipeline, fed directly by the ID/EX pipeline register and driving the EX/MEM register. It applies the forwarding-unit selects to the operands and computes the ALU result. It also owns a background iterative unsigned multiply/divide unit with HI/LO registers. The stage raises a stall whenever an instruction in EX needs HI/LO or the unit while it is still busy.

## Interface
- No parameters. Widths are fixed: 32-bit datapath, 32-iteration mul/div.
- clk  in  1  clock; reset  in  1  reset, asynchronous, active-high.
- ReadData1_in, ReadData2_in, SignExtImm_in  in  32 each  operands from ID/EX.
- Rt_in, Rd_in  in  5 each  destination candidates; Funct_in  in  6; ALUOp_in  in  4.
- RegDst_in, ALUSrc_in, MemtoReg_in, RegWrite_in, MemRead_in, MemWrite_in  in  1 each  control from ID/EX.
- ForwardA, ForwardB  in  2 each  operand selects: 00 ID/EX value, 10 ex_mem_result, 01 mem_wb_data, 11 treated as 00.
- ex_mem_result, mem_wb_data  in  32 each  forwarded values.
- ALUResult_out  out  32  combinational result to EX/MEM.
- WriteData_out  out  32  forwarded operand B, used as store data.
- WriteReg_out  out  5  equals Rd_in when RegDst_in is 1, else Rt_in.
- RegWrite_out, MemRead_out, MemWrite_out, MemtoReg_out  out  1 each  gated control to EX/MEM.
- ex_stall  out  1  hold request to PC, IF/ID and ID/EX. These hold their contents; they do not flush.
- muldiv_busy  out  1  mul/div iteration in progress.

## Operation
- Operand A is the ForwardA mux output. Operand B is SignExtImm_in when ALUSrc_in is 1, else the ForwardB mux output.
- ALUOp decode:
  - 0000: ADD.
  - 0001: SUB.
  - 0010: R-type, decoded by Funct.
  - 0011: AND.
  - 0100: OR.
  - 0101: SLT, signed.
  - 1111: bubble; result 0, no mul/div start.
  - Any other code: result 0.
- Funct decode for R-type:
  - 100000 ADD; 100010 SUB; 100100 AND; 100101 OR; 101010 SLT (signed).
  - 010000 MFHI; 010010 MFLO.
  - 011001 MULTU; 011011 DIVU.
  - Any other Funct: result 0.
- ADD and SUB wrap modulo 2^32 and raise no exceptions.
- MULTU and DIVU force RegWrite_out to 0. Their ALUResult_out is 0.
- Mul/div state: HI and LO (32 bits each), a 6-bit iteration counter, a 64-bit working register, a 32-bit divisor/multiplicand, and an op flag.
  - States: IDLE and RUN.
  - IDLE to RUN: on the edge where MULTU or DIVU is in EX and ex_stall is 0. That edge latches A and B and loads the counter with 32.
  - In RUN, each edge performs one iteration and decrements the counter.
  - On the edge where the counter goes from 1 to 0, HI/LO are written and the state returns to IDLE.
- MULTU: shift-add algorithm. Result {HI, LO} = A × B, unsigned, 64 bits.
- DIVU: restoring algorithm with a 33-bit partial remainder. LO = A / B, HI = A % B, both unsigned.
- Divide by zero: HI = A and LO = 32'hFFFF_FFFF. This is the natural restoring result; no flag is raised.
- muldiv_busy = 1 exactly while in RUN.
- ex_stall = muldiv_busy AND the EX instruction is one of MFHI, MFLO, MULTU, DIVU.
- While ex_stall = 1:
  - RegWrite_out, MemRead_out and MemWrite_out are forced to 0, which sends a bubble into EX/MEM.
  - No new mul/div starts.
- Independent instructions (ALU ops, loads, stores) flow through without stalling while the unit runs.
- MFHI/MFLO read the HI/LO register values present during their cycle in EX.

## Timing
- The ALU, forwarding muxes, WriteReg_out, gated control and ex_stall are combinational, with zero-cycle latency.
- Mul/div latency: accepted at edge E0; HI/LO are valid after edge E32.
- muldiv_busy is high for the 32 cycles between E0 and E32, and falls at E32.
- An MFHI/MFLO directly following MULTU is stalled for 32 cycles. It executes in the cycle after E32 and reads the new value.
- A second MULTU/DIVU issued back-to-back stalls identically and then starts at the edge after E32.
- Reset (asynchronous, at any time, including mid-RUN):
  - State returns to IDLE; counter = 0.
  - HI = LO = 0; working registers are cleared.
  - muldiv_busy = 0 and ex_stall = 0.
- Outputs under reset: combinational outputs follow the inputs. A bubble input (ALUOp 1111, all control 0) gives ALUResult_out = 0 and all control outputs 0.
- A reset that ends a partial operation leaves no residual write to HI/LO.

## Test plan
- Forwarding:
  - Setup: ReadData1 = 5, ex_mem_result = 7, mem_wb_data = 9; ALUOp 0010, Funct 100000, ALUSrc 0, ReadData2 = 1.
  - ForwardA = 10 gives ALUResult_out = 8; ForwardA = 01 gives 10; ForwardA = 00 gives 6.
- SLT signedness: A = 32'hFFFF_FFFF, B = 1 → ALUResult_out = 1. ADD of 32'h7FFF_FFFF + 1 → 32'h8000_0000.
- MULTU then MFHI/MFLO:
  - Stimulus: A = 32'hFFFF_FFFF, B = 2, then MFHI held in EX.
  - ex_stall is high for exactly 32 cycles with RegWrite_out = 0.
  - MFHI then yields 1; a following MFLO yields 32'hFFFF_FFFE.
- DIVU:
  - 100 / 7 gives LO = 14, HI = 2.
  - 5 / 0 gives LO = 32'hFFFF_FFFF, HI = 5.
  - An ADD issued during RUN is not stalled and produces its result.
- Reset mid-RUN: assert reset at iteration 10 of a MULTU → busy = 0 immediately, HI = LO = 0, and a following MFLO returns 0 without stalling.
- Back-to-back: MULTU 3×4 followed by DIVU 9/2 → DIVU stalls 32 cycles. Final HI = 1, LO = 4; the intermediate LO of 12 is observable only between the two operations.

Source files
------------

// File: rtl/ex_stage.sv
// Execute stage: forwarding muxes, ALU, and a background 32-iteration unsigned mul/div unit with HI/LO.
// Latency: ALU path is combinational (0 cycles); MULTU/DIVU results land in HI/LO 32 edges after acceptance.
// Backpressure: ex_stall holds upstream stages while an HI/LO reader or a new mul/div meets a busy unit.
module ex_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ReadData1_in,
    input  logic [31:0] ReadData2_in,
    input  logic [31:0] SignExtImm_in,
    input  logic [4:0]  Rt_in,
    input  logic [4:0]  Rd_in,
    input  logic [5:0]  Funct_in,
    input  logic [3:0]  ALUOp_in,
    input  logic        RegDst_in,
    input  logic        ALUSrc_in,
    input  logic        MemtoReg_in,
    input  logic        RegWrite_in,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic [1:0]  ForwardA,
    input  logic [1:0]  ForwardB,
    input  logic [31:0] ex_mem_result,
    input  logic [31:0] mem_wb_data,
    output logic [31:0] ALUResult_out,
    output logic [31:0] WriteData_out,
    output logic [4:0]  WriteReg_out,
    output logic        RegWrite_out,
    output logic        MemRead_out,
    output logic        MemWrite_out,
    output logic        MemtoReg_out,
    output logic        ex_stall,
    output logic        muldiv_busy
);

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_RTYPE = 4'b0010;
    localparam logic [3:0] OP_AND   = 4'b0011;
    localparam logic [3:0] OP_OR    = 4'b0100;
    localparam logic [3:0] OP_SLT   = 4'b0101;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIVU  = 6'b011011;

    typedef enum logic {S_IDLE, S_RUN} md_state_t;

    md_state_t   state_q;
    logic [5:0]  cnt_q;
    logic [63:0] work_q;
    logic [31:0] dvs_q;
    logic        op_div_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    logic [31:0] fwd_a;
    logic [31:0] fwd_b;
    logic [31:0] op_b;
    logic        is_rtype;
    logic        is_mfhi;
    logic        is_mflo;
    logic        is_multu;
    logic        is_divu;
    logic        is_md;
    logic        md_start;

    logic [32:0] mul_sum;
    logic [32:0] div_rem;
    logic [32:0] div_diff;
    logic [63:0] mul_d;
    logic [63:0] div_d;
    logic [63:0] work_d;

    // Operand forwarding: 10 picks EX/MEM, 01 picks MEM/WB, anything else uses the ID/EX value.
    always_comb begin
        fwd_a = ReadData1_in;
        fwd_b = ReadData2_in;
        case (ForwardA)
            2'b10:   fwd_a = ex_mem_result;
            2'b01:   fwd_a = mem_wb_data;
            default: fwd_a = ReadData1_in;
        endcase
        case (ForwardB)
            2'b10:   fwd_b = ex_mem_result;
            2'b01:   fwd_b = mem_wb_data;
            default: fwd_b = ReadData2_in;
        endcase
    end

    assign op_b     = ALUSrc_in ? SignExtImm_in : fwd_b;
    assign is_rtype = (ALUOp_in == OP_RTYPE);
    assign is_mfhi  = is_rtype && (Funct_in == FN_MFHI);
    assign is_mflo  = is_rtype && (Funct_in == FN_MFLO);
    assign is_multu = is_rtype && (Funct_in == FN_MULTU);
    assign is_divu  = is_rtype && (Funct_in == FN_DIVU);
    assign is_md    = is_multu || is_divu;

    assign muldiv_busy = (state_q == S_RUN);
    assign ex_stall    = muldiv_busy && (is_mfhi || is_mflo || is_md);
    // Unit can only be idle when not stalled, so this also implies IDLE.
    assign md_start    = is_md && !ex_stall;

    // ALU result; mul/div issue slots return zero, HI/LO moves read the current registers.
    always_comb begin
        ALUResult_out = 32'd0;
        case (ALUOp_in)
            OP_ADD: ALUResult_out = fwd_a + op_b;
            OP_SUB: ALUResult_out = fwd_a - op_b;
            OP_AND: ALUResult_out = fwd_a & op_b;
            OP_OR:  ALUResult_out = fwd_a | op_b;
            OP_SLT: ALUResult_out = {31'd0, $signed(fwd_a) < $signed(op_b)};
            OP_RTYPE: begin
                case (Funct_in)
                    FN_ADD:  ALUResult_out = fwd_a + op_b;
                    FN_SUB:  ALUResult_out = fwd_a - op_b;
                    FN_AND:  ALUResult_out = fwd_a & op_b;
                    FN_OR:   ALUResult_out = fwd_a | op_b;
                    FN_SLT:  ALUResult_out = {31'd0, $signed(fwd_a) < $signed(op_b)};
                    FN_MFHI: ALUResult_out = hi_q;
                    FN_MFLO: ALUResult_out = lo_q;
                    default: ALUResult_out = 32'd0;
                endcase
            end
            default: ALUResult_out = 32'd0;
        endcase
    end

    assign WriteData_out = fwd_b;
    assign WriteReg_out  = RegDst_in ? Rd_in : Rt_in;
    assign RegWrite_out  = RegWrite_in && !ex_stall && !is_md;
    assign MemRead_out   = MemRead_in && !ex_stall;
    assign MemWrite_out  = MemWrite_in && !ex_stall;
    assign MemtoReg_out  = MemtoReg_in;

    // One mul/div iteration: shift-add multiply or restoring divide on the working register.
    always_comb begin
        mul_sum  = {1'b0, work_q[63:32]} + (work_q[0] ? {1'b0, dvs_q} : 33'd0);
        mul_d    = {mul_sum, work_q[31:1]};
        div_rem  = {work_q[63:32], work_q[31]};
        div_diff = div_rem - {1'b0, dvs_q};
        if (!div_diff[32]) begin
            div_d = {div_diff[31:0], work_q[30:0], 1'b1};
        end else begin
            div_d = {div_rem[31:0], work_q[30:0], 1'b0};
        end
        work_d = op_div_q ? div_d : mul_d;
    end

    // Mul/div sequencer: latch operands on start, iterate 32 times, commit HI/LO on the last edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= 6'd0;
            work_q   <= 64'd0;
            dvs_q    <= 32'd0;
            op_div_q <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (md_start) begin
                        state_q  <= S_RUN;
                        cnt_q    <= 6'd32;
                        work_q   <= {32'd0, fwd_a};
                        dvs_q    <= op_b;
                        op_div_q <= is_divu;
                    end
                end
                S_RUN: begin
                    work_q <= work_d;
                    cnt_q  <= cnt_q - 6'd1;
                    if (cnt_q == 6'd1) begin
                        hi_q    <= work_d[63:32];
                        lo_q    <= work_d[31:0];
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: forwarding, ALU ops, mul/div results, stall timing, reset mid-operation.
// Instructions are driven just after the falling edge and outputs are sampled 1 time unit later.
// Stall waits are bounded; an expired bound shows up as a wrong stall count.
module tb_ex_stage;

    logic        clk;
    logic        reset;
    logic [31:0] ReadData1_in, ReadData2_in, SignExtImm_in;
    logic [4:0]  Rt_in, Rd_in;
    logic [5:0]  Funct_in;
    logic [3:0]  ALUOp_in;
    logic        RegDst_in, ALUSrc_in, MemtoReg_in, RegWrite_in, MemRead_in, MemWrite_in;
    logic [1:0]  ForwardA, ForwardB;
    logic [31:0] ex_mem_result, mem_wb_data;
    logic [31:0] ALUResult_out, WriteData_out;
    logic [4:0]  WriteReg_out;
    logic        RegWrite_out, MemRead_out, MemWrite_out, MemtoReg_out;
    logic        ex_stall, muldiv_busy;

    int total = 0;
    int bad   = 0;

    ex_stage dut (
        .clk(clk), .reset(reset),
        .ReadData1_in(ReadData1_in), .ReadData2_in(ReadData2_in), .SignExtImm_in(SignExtImm_in),
        .Rt_in(Rt_in), .Rd_in(Rd_in), .Funct_in(Funct_in), .ALUOp_in(ALUOp_in),
        .RegDst_in(RegDst_in), .ALUSrc_in(ALUSrc_in), .MemtoReg_in(MemtoReg_in),
        .RegWrite_in(RegWrite_in), .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
        .ForwardA(ForwardA), .ForwardB(ForwardB),
        .ex_mem_result(ex_mem_result), .mem_wb_data(mem_wb_data),
        .ALUResult_out(ALUResult_out), .WriteData_out(WriteData_out), .WriteReg_out(WriteReg_out),
        .RegWrite_out(RegWrite_out), .MemRead_out(MemRead_out), .MemWrite_out(MemWrite_out),
        .MemtoReg_out(MemtoReg_out), .ex_stall(ex_stall), .muldiv_busy(muldiv_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [5:0] FN_ADD = 6'b100000, FN_SLT = 6'b101010, FN_MFHI = 6'b010000;
    localparam logic [5:0] FN_MFLO = 6'b010010, FN_MULTU = 6'b011001, FN_DIVU = 6'b011011;

    task automatic drive_bubble();
        ReadData1_in = 0; ReadData2_in = 0; SignExtImm_in = 0;
        Rt_in = 0; Rd_in = 0; Funct_in = 0; ALUOp_in = 4'b1111;
        RegDst_in = 0; ALUSrc_in = 0; MemtoReg_in = 0; RegWrite_in = 0; MemRead_in = 0; MemWrite_in = 0;
        ForwardA = 2'b00; ForwardB = 2'b00; ex_mem_result = 0; mem_wb_data = 0;
    endtask

    // Drive one instruction into EX at the next falling edge, sampled 1 unit later.
    task automatic issue(input logic [3:0] op, input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        drive_bubble();
        ALUOp_in = op; Funct_in = fn; ReadData1_in = a; ReadData2_in = b;
        RegWrite_in = 1'b1; RegDst_in = 1'b1;
        #1;
    endtask

    // Hold the current instruction until ex_stall drops; returns cycles spent stalled.
    task automatic wait_release(output int n);
        n = 0;
        while (ex_stall === 1'b1 && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
    endtask

    task automatic test_reset();
        drive_bubble();
        reset = 1'b1;
        #23;
        total++; if (muldiv_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", muldiv_busy); end
        total++; if (ex_stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", ex_stall); end
        total++; if ({ALUResult_out, RegWrite_out, MemRead_out, MemWrite_out, MemtoReg_out} !== 36'd0) begin
            bad++; $display("FAIL reset_bubble got=%h/%b%b%b%b exp=0", ALUResult_out, RegWrite_out, MemRead_out, MemWrite_out, MemtoReg_out); end
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic test_forwarding();
        issue(4'b0010, FN_ADD, 32'd5, 32'd1);
        ex_mem_result = 32'd7; mem_wb_data = 32'd9;
        ForwardA = 2'b10; #1;
        total++; if (ALUResult_out !== 32'd8) begin bad++; $display("FAIL fwd_a_exmem got=%0d exp=8", ALUResult_out); end
        ForwardA = 2'b01; #1;
        total++; if (ALUResult_out !== 32'd10) begin bad++; $display("FAIL fwd_a_memwb got=%0d exp=10", ALUResult_out); end
        ForwardA = 2'b00; #1;
        total++; if (ALUResult_out !== 32'd6) begin bad++; $display("FAIL fwd_a_idex got=%0d exp=6", ALUResult_out); end
        ForwardA = 2'b11; ForwardB = 2'b10; #1;
        total++; if (ALUResult_out !== 32'd12 || WriteData_out !== 32'd7) begin
            bad++; $display("FAIL fwd_b_exmem got=%0d/%0d exp=12/7", ALUResult_out, WriteData_out); end
    endtask

    task automatic test_alu();
        issue(4'b0010, FN_SLT, 32'hFFFF_FFFF, 32'd1);
        total++; if (ALUResult_out !== 32'd1) begin bad++; $display("FAIL slt_signed got=%h exp=1", ALUResult_out); end
        issue(4'b0000, 6'd0, 32'h7FFF_FFFF, 32'd1);
        total++; if (ALUResult_out !== 32'h8000_0000) begin bad++; $display("FAIL add_wrap got=%h exp=80000000", ALUResult_out); end
        issue(4'b0001, 6'd0, 32'd3, 32'd5);
        total++; if (ALUResult_out !== 32'hFFFF_FFFE) begin bad++; $display("FAIL sub_wrap got=%h exp=fffffffe", ALUResult_out); end
        issue(4'b0011, 6'd0, 32'hF0F0_1234, 32'h0FF0_FF00);
        total++; if (ALUResult_out !== 32'h00F0_1200) begin bad++; $display("FAIL and got=%h exp=00f01200", ALUResult_out); end
        issue(4'b0100, 6'd0, 32'hF000_0000, 32'h0000_000F);
        ALUSrc_in = 1'b1; SignExtImm_in = 32'h0000_0F00; Rt_in = 5'd3; Rd_in = 5'd17; RegDst_in = 1'b0; #1;
        total++; if (ALUResult_out !== 32'hF000_0F00 || WriteReg_out !== 5'd3) begin
            bad++; $display("FAIL or_imm_rt got=%h/%0d exp=f0000f00/3", ALUResult_out, WriteReg_out); end
        issue(4'b0110, 6'd0, 32'd9, 32'd9);
        total++; if (ALUResult_out !== 32'd0) begin bad++; $display("FAIL bad_op got=%h exp=0", ALUResult_out); end
    endtask

    task automatic test_multu();
        int n;
        issue(4'b0010, FN_MULTU, 32'hFFFF_FFFF, 32'd2);
        total++; if (RegWrite_out !== 1'b0 || ALUResult_out !== 32'd0 || ex_stall !== 1'b0) begin
            bad++; $display("FAIL multu_issue got=%b/%h/%b exp=0/0/0", RegWrite_out, ALUResult_out, ex_stall); end
        issue(4'b0010, FN_MFHI, 32'd0, 32'd0);
        n = 0;
        while (ex_stall === 1'b1 && n < 100) begin
            total++; if (RegWrite_out !== 1'b0) begin bad++; $display("FAIL stall_regwrite got=%b exp=0", RegWrite_out); end
            @(negedge clk); #1;
            n++;
        end
        total++; if (n !== 32) begin bad++; $display("FAIL multu_stall_len got=%0d exp=32", n); end
        total++; if (ALUResult_out !== 32'd1 || muldiv_busy !== 1'b0 || RegWrite_out !== 1'b1) begin
            bad++; $display("FAIL mfhi got=%h/%b/%b exp=1/0/1", ALUResult_out, muldiv_busy, RegWrite_out); end
        issue(4'b0010, FN_MFLO, 32'd0, 32'd0);
        total++; if (ALUResult_out !== 32'hFFFF_FFFE) begin bad++; $display("FAIL mflo got=%h exp=fffffffe", ALUResult_out); end
    endtask

    task automatic test_divu();
        int n;
        issue(4'b0010, FN_DIVU, 32'd100, 32'd7);
        issue(4'b0010, FN_ADD, 32'd3, 32'd4);
        total++; if (ex_stall !== 1'b0 || muldiv_busy !== 1'b1 || ALUResult_out !== 32'd7 || RegWrite_out !== 1'b1) begin
            bad++; $display("FAIL add_during_run got=%b/%b/%0d/%b exp=0/1/7/1", ex_stall, muldiv_busy, ALUResult_out, RegWrite_out); end
        issue(4'b0010, FN_MFLO, 32'd0, 32'd0);
        wait_release(n);
        total++; if (n !== 31 || ALUResult_out !== 32'd14) begin bad++; $display("FAIL divu_lo got=%0d stall=%0d exp=14 stall=31", ALUResult_out, n); end
        issue(4'b0010, FN_MFHI, 32'd0, 32'd0);
        total++; if (ALUResult_out !== 32'd2) begin bad++; $display("FAIL divu_hi got=%0d exp=2", ALUResult_out); end
        issue(4'b0010, FN_DIVU, 32'd5, 32'd0);
        issue(4'b0010, FN_MFHI, 32'd0, 32'd0);
        wait_release(n);
        total++; if (n !== 32 || ALUResult_out !== 32'd5) begin bad++; $display("FAIL div0_hi got=%h stall=%0d exp=5 stall=32", ALUResult_out, n); end
        issue(4'b0010, FN_MFLO, 32'd0, 32'd0);
        total++; if (ALUResult_out !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div0_lo got=%h exp=ffffffff", ALUResult_out); end
    endtask

    task automatic test_reset_mid_run();
        issue(4'b0010, FN_MULTU, 32'd3, 32'd5);
        @(negedge clk); drive_bubble();
        repeat (9) @(negedge clk);
        #1;
        total++; if (muldiv_busy !== 1'b1) begin bad++; $display("FAIL busy_before_reset got=%b exp=1", muldiv_busy); end
        reset = 1'b1; #1;
        total++; if (muldiv_busy !== 1'b0 || ex_stall !== 1'b0) begin
            bad++; $display("FAIL reset_mid_run got=%b/%b exp=0/0", muldiv_busy, ex_stall); end
        @(negedge clk); reset = 1'b0;
        issue(4'b0010, FN_MFLO, 32'd0, 32'd0);
        total++; if (ex_stall !== 1'b0 || ALUResult_out !== 32'd0) begin
            bad++; $display("FAIL mflo_after_reset got=%b/%h exp=0/0", ex_stall, ALUResult_out); end
        @(negedge clk); drive_bubble();
        repeat (30) @(negedge clk);
        issue(4'b0010, FN_MFHI, 32'd0, 32'd0);
        total++; if (ALUResult_out !== 32'd0 || muldiv_busy !== 1'b0) begin
            bad++; $display("FAIL no_residual_write got=%h/%b exp=0/0", ALUResult_out, muldiv_busy); end
    endtask

    task automatic test_back_to_back();
        int n;
        issue(4'b0010, FN_MULTU, 32'd3, 32'd4);
        issue(4'b0010, FN_DIVU, 32'd9, 32'd2);
        wait_release(n);
        total++; if (n !== 32) begin bad++; $display("FAIL b2b_stall_len got=%0d exp=32", n); end
        total++; if (muldiv_busy !== 1'b0 || RegWrite_out !== 1'b0) begin
            bad++; $display("FAIL b2b_release got=%b/%b exp=0/0", muldiv_busy, RegWrite_out); end
        issue(4'b0010, FN_MFHI, 32'd0, 32'd0);
        total++; if (ex_stall !== 1'b1) begin bad++; $display("FAIL b2b_div_started got=%b exp=1", ex_stall); end
        wait_release(n);
        total++; if (ALUResult_out !== 32'd1) begin bad++; $display("FAIL b2b_hi got=%h exp=1", ALUResult_out); end
        issue(4'b0010, FN_MFLO, 32'd0, 32'd0);
        total++; if (ALUResult_out !== 32'd4) begin bad++; $display("FAIL b2b_lo got=%h exp=4", ALUResult_out); end
    endtask

    initial begin
        test_reset();
        test_forwarding();
        test_alu();
        test_multu();
        test_divu();
        test_reset_mid_run();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
